// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between instruction fetch and data
// load/store. One requester is granted at a time. The granted request is
// registered onto mem_* and held until mem_ready, or until the watchdog
// expires. The result is then returned with a one-cycle ack.
//
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_rdata/if_ack            fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack   data requester
//   mem_valid/mem_we/mem_addr/mem_wdata -> memory; mem_rdata/mem_ready <- memory
//   bus_err  pulses with the ack of an access that timed out
//   grant_d  current or most recent owner (1 = data, 0 = fetch)
//
// state  | meaning
// IDLE   | arbitrate this cycle's requests and register the winner onto mem_*
// ACCESS | mem_valid high, waiting for mem_ready or watchdog expiry
// RESP   | one-cycle ack (and bus_err) to the owner; requests ignored
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] wd_cnt;

  logic starve_hit;
  logic grant_f_w;
  logic grant_d_w;

  // Data wins contention unless fetch has already been passed over
  // STARVE_LIMIT times in a row.
  always_comb begin
    starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
    grant_f_w  = if_req & (~d_req | starve_hit);
    grant_d_w  = d_req & ~grant_f_w;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
      grant_d    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          bus_err <= 1'b0;
          if (grant_f_w || grant_d_w) begin
            mem_valid <= 1'b1;
            grant_d   <= grant_d_w;
            // Watchdog is a down-counter; terminal count 0 marks the
            // TIMEOUT-th ACCESS cycle.
            wd_cnt    <= 8'(TIMEOUT - 1);
            state     <= ACCESS;
            if (grant_d_w) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              if (!if_req)
                starve_cnt <= '0;
              else if (!starve_hit)
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            // Ready on the expiry cycle still counts as success.
            mem_valid <= 1'b0;
            bus_err   <= 1'b0;
            state     <= RESP;
            if (grant_d) begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else if (wd_cnt == 8'd0) begin
            mem_valid <= 1'b0;
            bus_err   <= 1'b1;
            state     <= RESP;
            if (grant_d) begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt - 8'd1;
          end
        end

        RESP: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          bus_err <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
